// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter in front of a single SDRAM controller port.
// Latches the winning burst, forwards it, and masks stale requests for two cycles after each burst.
module sdram_port_arbiter #(
  parameter int DW  = 16,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_done,

  input  logic          c0_wr_req,
  input  logic          c0_rd_req,
  input  logic [23:0]   c0_wr_addr,
  input  logic [23:0]   c0_rd_addr,
  input  logic [9:0]    c0_wr_len,
  input  logic [9:0]    c0_rd_len,
  input  logic [DW-1:0] c0_din,
  output logic          c0_wr_ack,
  output logic          c0_rd_ack,
  output logic [DW-1:0] c0_dout,

  input  logic          c1_wr_req,
  input  logic          c1_rd_req,
  input  logic [23:0]   c1_wr_addr,
  input  logic [23:0]   c1_rd_addr,
  input  logic [9:0]    c1_wr_len,
  input  logic [9:0]    c1_rd_len,
  input  logic [DW-1:0] c1_din,
  output logic          c1_wr_ack,
  output logic          c1_rd_ack,
  output logic [DW-1:0] c1_dout,

  output logic          m_wr_req,
  output logic          m_rd_req,
  input  logic          m_wr_ack,
  input  logic          m_rd_ack,
  output logic [23:0]   m_wr_addr,
  output logic [23:0]   m_rd_addr,
  output logic [9:0]    m_wr_len,
  output logic [9:0]    m_rd_len,
  output logic [DW-1:0] m_din,
  input  logic [DW-1:0] m_dout,

  output logic          grant_id,
  output logic          busy,
  output logic          tmo_err
);

  // state | meaning
  // IDLE  | waiting for init_done and a client request
  // REQ   | m_*_req asserted, waiting for controller ack
  // BUSY  | burst running, waiting for ack to fall
  // HOLD  | two quiet cycles so stale client requests are ignored
  typedef enum logic [1:0] {IDLE, REQ, BUSY, HOLD} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t      state;
  logic        rr;
  logic        dir_wr;
  logic [7:0]  cnt;
  logic        hold_cnt;

  logic [1:0]  wr_v;
  logic [1:0]  rd_v;
  logic        win_valid;
  logic        win_id;
  logic        win_wr;
  logic [23:0] win_addr;
  logic [9:0]  win_len;
  logic        gnt_req;
  logic        gnt_ack;
  logic        in_burst;

  assign wr_v = {c1_wr_req, c0_wr_req};
  assign rd_v = {c1_rd_req, c0_rd_req};

  // Client rr is examined first; within a client a write beats a read.
  always_comb begin
    win_valid = 1'b0;
    win_id    = rr;
    win_wr    = 1'b0;
    if (wr_v[rr]) begin
      win_valid = 1'b1;
      win_id    = rr;
      win_wr    = 1'b1;
    end else if (rd_v[rr]) begin
      win_valid = 1'b1;
      win_id    = rr;
      win_wr    = 1'b0;
    end else if (wr_v[~rr]) begin
      win_valid = 1'b1;
      win_id    = ~rr;
      win_wr    = 1'b1;
    end else if (rd_v[~rr]) begin
      win_valid = 1'b1;
      win_id    = ~rr;
      win_wr    = 1'b0;
    end
  end

  always_comb begin
    win_addr = c0_wr_addr;
    win_len  = c0_wr_len;
    case ({win_id, win_wr})
      2'b01:   begin win_addr = c0_wr_addr; win_len = c0_wr_len; end
      2'b00:   begin win_addr = c0_rd_addr; win_len = c0_rd_len; end
      2'b11:   begin win_addr = c1_wr_addr; win_len = c1_wr_len; end
      default: begin win_addr = c1_rd_addr; win_len = c1_rd_len; end
    endcase
  end

  assign gnt_req = dir_wr ? wr_v[grant_id] : rd_v[grant_id];
  assign gnt_ack = dir_wr ? m_wr_ack : m_rd_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      grant_id  <= 1'b0;
      dir_wr    <= 1'b0;
      cnt       <= 8'd0;
      hold_cnt  <= 1'b0;
      m_wr_req  <= 1'b0;
      m_rd_req  <= 1'b0;
      m_wr_addr <= 24'd0;
      m_rd_addr <= 24'd0;
      m_wr_len  <= 10'd0;
      m_rd_len  <= 10'd0;
      tmo_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init_done && win_valid) begin
            state    <= REQ;
            grant_id <= win_id;
            dir_wr   <= win_wr;
            cnt      <= 8'd0;
            if (win_wr) begin
              m_wr_req  <= 1'b1;
              m_wr_addr <= win_addr;
              m_wr_len  <= win_len;
            end else begin
              m_rd_req  <= 1'b1;
              m_rd_addr <= win_addr;
              m_rd_len  <= win_len;
            end
          end
        end
        REQ: begin
          if (gnt_ack) begin
            m_wr_req <= 1'b0;
            m_rd_req <= 1'b0;
            state    <= BUSY;
          end else if (!gnt_req) begin
            m_wr_req <= 1'b0;
            m_rd_req <= 1'b0;
            state    <= IDLE;
          end else if (cnt == TMO_LAST) begin
            m_wr_req <= 1'b0;
            m_rd_req <= 1'b0;
            tmo_err  <= 1'b1;
            rr       <= ~rr;
            hold_cnt <= 1'b0;
            state    <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // BUSY is only entered with ack sampled high, so a low sample here is the falling edge.
        BUSY: begin
          if (!gnt_ack) begin
            rr       <= ~grant_id;
            hold_cnt <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt) state <= IDLE;
          else          hold_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign in_burst = (state == REQ) || (state == BUSY);

  assign c0_wr_ack = m_wr_ack & in_burst &  dir_wr & ~grant_id;
  assign c0_rd_ack = m_rd_ack & in_burst & ~dir_wr & ~grant_id;
  assign c1_wr_ack = m_wr_ack & in_burst &  dir_wr &  grant_id;
  assign c1_rd_ack = m_rd_ack & in_burst & ~dir_wr &  grant_id;

  assign m_din   = grant_id ? c1_din : c0_din;
  assign c0_dout = m_dout;
  assign c1_dout = m_dout;

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter DW, default 16, SDRAM data width; parameter TMO, default 255, request-to-ack timeout in cycles (range 1..255).
REQ-002 clk  in  1  SDRAM controller clock; all logic on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 init_done  in  1  SDRAM initialisation complete.
REQ-005 cN_wr_req / cN_rd_req  in  1 each  client N (N=0,1) write/read burst request, level-held.
REQ-006 cN_wr_addr / cN_rd_addr  in  24 each  client N burst start address.
REQ-007 cN_wr_len / cN_rd_len  in  10 each  client N burst length.
REQ-008 cN_din  in  DW  client N write data.
REQ-009 cN_wr_ack / cN_rd_ack  out  1 each  acks routed to client N.
REQ-010 cN_dout  out  DW  read data to client N.
REQ-011 m_wr_req, m_rd_req  out  1  requests to SDRAM controller.
REQ-012 m_wr_ack, m_rd_ack  in  1  acks from SDRAM controller.
REQ-013 m_wr_addr, m_rd_addr  out  24  latched granted address.
REQ-014 m_wr_len, m_rd_len  out  10  latched granted length.
REQ-015 m_din  out  DW  write data; m_dout  in  DW  read data.
REQ-016 grant_id  out  1  client currently granted; busy  out  1  high in any state but IDLE.
REQ-017 tmo_err  out  1  sticky timeout flag.

Function
REQ-018 FSM states IDLE, REQ, BUSY, HOLD; one-hot or binary encoding is free.
REQ-019 IDLE: when init_done=1 and any request is high, latch winner's client id, direction, address and length; next state REQ.
REQ-020 Arbitration: round-robin between clients via 1-bit pointer rr; client rr checked first; within a client, write beats read.
REQ-021 REQ: assert m_wr_req or m_rd_req (per latched direction) from the cycle REQ is entered, held until the matching m_*_ack is sampled high; then deassert and enter BUSY.
REQ-022 REQ: if the granted client's request drops before ack, deassert m_*_req next cycle and return to IDLE; rr unchanged.
REQ-023 REQ: 8-bit counter from 0; reaching TMO without ack -> set tmo_err, deassert m_*_req, go to HOLD; rr toggles.
REQ-024 BUSY: on falling edge of the granted m_*_ack (sampled 1 then 0), go to HOLD; rr <= ~grant_id.
REQ-025 HOLD: exactly 2 cycles, no request asserted, then IDLE; masks stale client requests that drop after ack falls.
REQ-026 cN_wr_ack = m_wr_ack only while granted client=N and direction=write and state in {REQ, BUSY}; else 0 (combinational); read likewise.
REQ-027 m_din = cN_din of latched grant_id (combinational mux); cN_dout = m_dout broadcast to both clients.
REQ-028 m_*_addr and m_*_len stable from REQ entry until IDLE re-entry; never change mid-burst.
REQ-029 At most one of m_wr_req, m_rd_req high at any time.
REQ-030 init_done low in IDLE: no grant; init_done falling in REQ/BUSY: no effect on current burst.
REQ-031 Simultaneous: all four requests high -> grant order over successive bursts c(rr)_wr, c(~rr)_wr, c(rr)_wr, ...; a client's read only wins when its write is low.

Reset
REQ-032 rst_n low: state IDLE, rr=0, grant_id=0, all req/ack outputs 0, addr/len outputs 0, counters 0, tmo_err 0.
REQ-033 Reset mid-burst: outputs clear asynchronously; no burst resumes after release.

Verification
REQ-034 Reset, init_done=1, c0_wr_req=1 addr 0x000100 len 256 -> m_wr_req=1 one cycle after request sampled, m_wr_addr=0x000100, m_wr_len=256, grant_id=0.
REQ-035 c0_wr_req and c1_rd_req high together, rr=0 -> c0 write served first; after ack falls + 2 HOLD cycles, c1 read granted, c1_rd_ack mirrors m_rd_ack, c0_rd_ack stays 0.
REQ-036 All four requests high for 4 bursts -> order c0_wr, c1_wr, c0_wr, c1_wr; m_wr_req and m_rd_req never both high.
REQ-037 Grant c1 read, never drive m_rd_ack, TMO=16 -> m_rd_req drops after 16 cycles, tmo_err=1 and remains 1 until reset.
REQ-038 c0_wr_req withdrawn in REQ before ack -> m_wr_req low next cycle, FSM IDLE, rr unchanged.
REQ-039 rst_n pulsed low mid-BUSY -> all outputs 0 immediately; pending requests re-arbitrate from rr=0 after release.
